// File: rtl/timer_cnt_div.sv
// Timer counting stage: 2^div_val prescaler feeding a 64-bit counter with TDR byte-merge writes.
// Build option: define TIMER_HALT_EN to let halt_req freeze counting; otherwise halt_req is ignored.
module timer_cnt_div #(
  parameter int CNT_W   = 64,
  parameter int DIV_W   = 4,
  parameter int MAX_DIV = 8,
  parameter int INT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             timer_en_neg,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             halt_req,
  input  logic             tdr0_wr_sel,
  input  logic             tdr1_wr_sel,
  input  logic [3:0]       pstrb,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_en
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [INT_W-1:0] int_cnt_q, int_cnt_d;
  logic             halt;
  logic             active;
  logic [DIV_W-1:0] div_eff;
  logic [INT_W:0]   pow2;
  logic [INT_W-1:0] limit;
  logic             at_limit;
  logic             tdr_wr;
  logic [CNT_W/8-1:0] byte_we;
  logic [CNT_W-1:0] wr_cnt;

`ifdef TIMER_HALT_EN
  assign halt = halt_req;
`else
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halt = 1'b0;
`endif

  assign active = timer_en & ~halt;

  // Out-of-range selects saturate at the largest legal ratio.
  assign div_eff  = (div_val > DIV_W'(MAX_DIV)) ? DIV_W'(MAX_DIV) : div_val;
  assign pow2     = (INT_W+1)'(1) << div_eff;
  assign limit    = pow2[INT_W-1:0] - INT_W'(1);
  assign at_limit = (int_cnt_q == limit);

  assign cnt_en = (~div_en || (div_eff == '0)) ? active : (active & at_limit);

  always_comb begin
    int_cnt_d = int_cnt_q;
    if (~timer_en || timer_en_neg) begin
      int_cnt_d = '0;
    end else if (halt) begin
      int_cnt_d = int_cnt_q;
    end else if (~div_en) begin
      int_cnt_d = '0;
    end else if (at_limit) begin
      int_cnt_d = '0;
    end else begin
      int_cnt_d = int_cnt_q + INT_W'(1);
    end
  end

  // Bytes 0-3 belong to TDR0, bytes 4-7 to TDR1; both share the same strobe lanes.
  assign tdr_wr = tdr0_wr_sel | tdr1_wr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_W/8; gi++) begin : g_byte
      localparam int LANE = gi % 4;
      if (gi < 4) begin : g_lo
        assign byte_we[gi] = tdr0_wr_sel & pstrb[LANE];
      end else begin : g_hi
        assign byte_we[gi] = tdr1_wr_sel & pstrb[LANE];
      end
      assign wr_cnt[gi*8 +: 8] = byte_we[gi] ? wdata[LANE*8 +: 8] : cnt_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (timer_en_neg) begin
      cnt_d = '0;
    end else if (tdr_wr) begin
      cnt_d = wr_cnt;
    end else if (cnt_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      int_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      int_cnt_q <= int_cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_timer_cnt_div.sv
// Directed bench for timer_cnt_div: stimulus queues expected cnt/cnt_en, a negedge monitor checks them.
module tb_timer_cnt_div;

  logic        clk;
  logic        rst_n;
  logic        timer_en;
  logic        timer_en_neg;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        tdr0_wr_sel;
  logic        tdr1_wr_sel;
  logic [3:0]  pstrb;
  logic [31:0] wdata;
  logic [63:0] cnt;
  logic        cnt_en;

  int total = 0;
  int bad   = 0;

  string       q_name[$];
  logic [63:0] q_cnt[$];
  logic        q_en[$];

  timer_cnt_div dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .timer_en     (timer_en),
    .timer_en_neg (timer_en_neg),
    .div_en       (div_en),
    .div_val      (div_val),
    .halt_req     (halt_req),
    .tdr0_wr_sel  (tdr0_wr_sel),
    .tdr1_wr_sel  (tdr1_wr_sel),
    .pstrb        (pstrb),
    .wdata        (wdata),
    .cnt          (cnt),
    .cnt_en       (cnt_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q_name.size() > 0) begin
      string       nm;
      logic [63:0] ec;
      logic        ee;
      nm = q_name.pop_front();
      ec = q_cnt.pop_front();
      ee = q_en.pop_front();
      total = total + 1;
      if (cnt !== ec || cnt_en !== ee) begin
        bad = bad + 1;
        $display("FAIL %s: cnt=%h cnt_en=%b expected cnt=%h cnt_en=%b", nm, cnt, cnt_en, ec, ee);
      end else begin
        $display("ok   %s: cnt=%h cnt_en=%b", nm, cnt, cnt_en);
      end
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic [63:0] ecnt, input logic een);
    q_name.push_back(nm);
    q_cnt.push_back(ecnt);
    q_en.push_back(een);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t5_final;
    rst_n = 1'b0; timer_en = 1'b0; timer_en_neg = 1'b0; div_en = 1'b0; div_val = 4'd0;
    halt_req = 1'b0; tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0; pstrb = 4'd0; wdata = 32'd0;
    @(posedge clk); #1;
    cyc("reset", 64'd0, 1'b0);
    rst_n = 1'b1;
    cyc("reset_rel", 64'd0, 1'b0);

    // Undivided counting
    timer_en = 1'b1;
    for (int i = 0; i < 10; i++) cyc("t1_run", 64'(i), 1'b1);
    timer_en = 1'b0;
    cyc("t1_hold", 64'd10, 1'b0);
    timer_en_neg = 1'b1;
    cyc("t1_neg", 64'd10, 1'b0);
    timer_en_neg = 1'b0;
    cyc("t1_cleared", 64'd0, 1'b0);

    // Divide by 4
    timer_en = 1'b1; div_en = 1'b1; div_val = 4'd2;
    for (int i = 0; i < 16; i++) cyc("t2_div4", 64'(i / 4), (i % 4) == 3);
    cyc("t2_end", 64'd4, 1'b0);

    // TDR1 partial write while counting from zero
    timer_en = 1'b0; timer_en_neg = 1'b1;
    cyc("t3_clr", 64'd4, 1'b0);
    timer_en = 1'b1; timer_en_neg = 1'b0; div_en = 1'b0;
    tdr1_wr_sel = 1'b1; pstrb = 4'b0011; wdata = 32'h0000_ABCD;
    cyc("t3_wr", 64'd0, 1'b1);
    tdr1_wr_sel = 1'b0; pstrb = 4'd0; wdata = 32'd0;
    cyc("t3_after", 64'h0000_ABCD_0000_0000, 1'b1);
    cyc("t3_inc", 64'h0000_ABCD_0000_0001, 1'b1);

    // TDR0 write on a tick cycle keeps the prescaler phase
    div_en = 1'b1; div_val = 4'd1;
    cyc("t3b_a", 64'h0000_ABCD_0000_0002, 1'b0);
    tdr0_wr_sel = 1'b1; pstrb = 4'b1000; wdata = 32'h5A00_0000;
    cyc("t3b_wr", 64'h0000_ABCD_0000_0002, 1'b1);
    tdr0_wr_sel = 1'b0; pstrb = 4'd0; wdata = 32'd0;
    cyc("t3b_b", 64'h0000_ABCD_5A00_0002, 1'b0);
    cyc("t3b_c", 64'h0000_ABCD_5A00_0002, 1'b1);
    cyc("t3b_d", 64'h0000_ABCD_5A00_0003, 1'b0);

    // Preset all-ones then wrap
    div_en = 1'b0;
    tdr0_wr_sel = 1'b1; tdr1_wr_sel = 1'b1; pstrb = 4'hF; wdata = 32'hFFFF_FFFF;
    cyc("t4_wr", 64'h0000_ABCD_5A00_0003, 1'b1);
    tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0; pstrb = 4'd0; wdata = 32'd0;
    cyc("t4_max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    cyc("t4_wrap", 64'd0, 1'b1);

    // Halt mid-prescale with divide by 8
    timer_en = 1'b0; timer_en_neg = 1'b1;
    cyc("t5_clr", 64'd1, 1'b0);
    timer_en = 1'b1; timer_en_neg = 1'b0; div_en = 1'b1; div_val = 4'd3;
    for (int j = 0; j < 3; j++) cyc("t5_pre", 64'd0, 1'b0);
    halt_req = 1'b1;
`ifdef TIMER_HALT_EN
    for (int k = 0; k < 5; k++) cyc("t5_halt", 64'd0, 1'b0);
    halt_req = 1'b0;
    for (int p = 0; p < 9; p++) cyc("t5_post", (p > 4) ? 64'd1 : 64'd0, p == 4);
    t5_final = 64'd1;
`else
    for (int k = 0; k < 5; k++) cyc("t5_halt_ign", 64'd0, k == 4);
    halt_req = 1'b0;
    for (int p = 0; p < 9; p++) cyc("t5_post", (p > 7) ? 64'd2 : 64'd1, p == 7);
    t5_final = 64'd2;
`endif

    // Count to 7 then stop the timer
    timer_en = 1'b0; timer_en_neg = 1'b1;
    cyc("t6_clr", t5_final, 1'b0);
    timer_en = 1'b1; timer_en_neg = 1'b0; div_en = 1'b0;
    for (int i = 0; i < 7; i++) cyc("t6_run", 64'(i), 1'b1);
    timer_en = 1'b0; timer_en_neg = 1'b1;
    cyc("t6_neg", 64'd7, 1'b0);
    timer_en_neg = 1'b0;
    cyc("t6_zero", 64'd0, 1'b0);
    timer_en = 1'b1; div_en = 1'b1; div_val = 4'd1;
    cyc("t6_ph0", 64'd0, 1'b0);
    cyc("t6_ph1", 64'd0, 1'b1);
    cyc("t6_ph2", 64'd1, 1'b0);

    // Illegal div_val saturates to divide by 256
    timer_en = 1'b0; timer_en_neg = 1'b1;
    cyc("t7_clr", 64'd1, 1'b0);
    timer_en = 1'b1; timer_en_neg = 1'b0; div_en = 1'b1; div_val = 4'd15;
    for (int i = 0; i < 256; i++) cyc("t7_div256", 64'd0, i == 255);
    cyc("t7_end", 64'd1, 1'b0);

    // Asynchronous reset mid-count
    div_en = 1'b0;
    cyc("t8_run", 64'd1, 1'b1);
    cyc("t8_run", 64'd2, 1'b1);
    rst_n = 1'b0; timer_en = 1'b0;
    cyc("t8_async_rst", 64'd0, 1'b0);
    rst_n = 1'b1;
    cyc("t8_rel", 64'd0, 1'b0);

    for (int w = 0; w < 10 && q_name.size() > 0; w++) @(posedge clk);
    if (q_name.size() > 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left, required 0", q_name.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
